cpu_pipe_stage: RTL and testbench
=================================

# cpu_pipe_stage

Parametrised pipeline stage register: the generic successor to the fixed ID/EX register, usable at every CPU stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries an opaque WIDTH-bit payload, typically a packed stage struct. It adds a valid/ready handshake, synchronous flush with bubble insertion, an optional 2-entry skid mode that registers backpressure, and a saturating stall counter for performance monitoring.

## Interface
- WIDTH, 32, payload width in bits; set to the bit width of the stage struct
- SKID, 1, 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready
- BUBBLE, '0, WIDTH-bit value driven on out_data when the stage is empty (the NOP encoding)
- CNT_W, 16, stall counter width
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage accepts payload this cycle
- in_data  input  WIDTH  upstream payload
- flush  input  1  synchronous kill of all held and incoming payloads
- out_valid  output  1  payload valid to downstream
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  payload to downstream; equals BUBBLE when out_valid=0
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Transfer rules: push = in_valid & in_ready; pop = out_valid & out_ready. Payloads leave in the order they were accepted. No payload is duplicated or lost, except by flush.
- Occupancy state (pipe_occ_e):
  - EMPTY: no payload held. out_valid=0.
  - BUSY: main entry valid. out_valid=1, out_data = main.
  - FULL: main and skid entries valid. Reachable only when SKID=1.
- Transitions:
  - EMPTY: push -> BUSY, main <= in_data.
  - BUSY, push & pop -> BUSY, main <= in_data.
  - BUSY, pop only -> EMPTY, main <= BUBBLE.
  - BUSY, push only -> with SKID=1: FULL, skid <= in_data. With SKID=0 this cannot occur, because in_ready=0.
  - FULL, pop -> BUSY, main <= skid, skid <= BUBBLE.
  - FULL, no pop -> hold.
- in_ready:
  - SKID=0: in_ready = !flush & (state==EMPTY | out_ready). Combinational from out_ready.
  - SKID=1: in_ready = !flush & (state!=FULL). Depends on state only, with no path from out_ready.
- Flush: takes priority over push and pop.
  - Next state is EMPTY. All entries are set to BUBBLE.
  - in_ready=0 during flush, so the incoming beat is not accepted.
  - A pop presented in the flush cycle still completes, since out_valid was already 1.
  - stall_cnt is not cleared.
- stall_cnt: increments by 1 in each cycle with out_valid & !out_ready. Saturates at 2^CNT_W-1 and holds there. Cleared only by reset.
- Reset: takes priority over flush. state=EMPTY, main=skid=BUBBLE, out_valid=0, out_data=BUBBLE, stall_cnt=0. in_ready is 1 in the first cycle after reset deasserts.

## Timing
- Latency: 1 cycle. A beat pushed at edge N is on out_data after edge N, with no bypass path.
- Throughput: 1 beat per cycle when out_ready is held at 1, for both SKID values.
- SKID=1: after out_ready drops, at most one further beat is absorbed (into skid), then in_ready=0 from the next cycle. When out_ready rises with the stage FULL, in_ready rises the cycle after the pop.
- All outputs are register outputs, except in_ready when SKID=0.
- Reset asserted mid-stream: outputs show reset values at the next edge. In-flight payloads are discarded.

## Structure
- cpu_pkg additions:
  - typedef enum logic [1:0] pipe_occ_e {EMPTY, BUSY, FULL}.
  - Bubble constants per stage, e.g. ID_EX_BUBBLE (opcode NA, all other fields 0), passed as BUBBLE.
- Sub-module cpu_pipe_skid: the two-entry main/skid storage plus the state machine. cpu_pipe_stage wraps it and adds in_ready generation, flush, and stall_cnt. For SKID=0 the skid entry is not instantiated.
- Stage wrappers such as the ID/EX boundary instantiate cpu_pipe_stage with WIDTH=$bits(ID_EX_pipe_t), then pack and unpack the struct at the ports.

## Test plan
Benches use WIDTH=8, BUBBLE=8'hFF, CNT_W=4.
- Streaming: push 0x01..0x10 with out_ready=1 continuously, both SKID values -> out_data shows 0x01..0x10 one cycle after each push, with no gaps; stall_cnt stays 0.
- Backpressure, SKID=1: push 0x01,0x02,0x03 back to back with out_ready=0 from cycle 1 -> state FULL holding 0x01/0x02, in_ready=0, 0x03 held upstream. Raise out_ready -> output sequence 0x01,0x02,0x03 in order.
- Backpressure, SKID=0: out_valid=1 with out_ready=0 -> in_ready=0 in the same cycle. Assert out_ready and in_valid together -> pop and push complete in the same cycle.
- Flush while FULL and in_valid=1 (0x07) -> next cycle out_valid=0, out_data=0xFF, and 0x07 is not accepted (in_ready=0 during flush).
- Saturation: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays there; a later flush leaves it at 15; reset clears it to 0.
- Reset mid-stream with the stage FULL -> next cycle out_valid=0, out_data=0xFF, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and constants.
//   pipe_occ_e    occupancy state of a pipeline stage register
//   op_e          decoded operation class carried down the pipe
//   ID_EX_pipe_t  payload crossing the ID/EX boundary
//   ID_EX_BUBBLE  NOP encoding for the ID/EX boundary (opcode NA, all else 0)
package cpu_pkg;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_occ_e;

  typedef enum logic [2:0] {NA, ALU, LOAD, STORE, BRANCH} op_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } ID_EX_pipe_t;

  localparam ID_EX_pipe_t ID_EX_BUBBLE = '{op: NA, default: '0};

endpackage

// File: rtl/cpu_pipe_skid.sv
// cpu_pipe_skid: main/skid payload storage plus the occupancy state machine.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   flush        drop every held payload (beats the push/pop handshake)
//   push, pop    qualified transfers computed by the wrapper
//   in_data      payload written on push
//   state        current occupancy (EMPTY/BUSY/FULL)
//   main         head payload; BUBBLE when empty
module cpu_pipe_skid
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter bit               SKID   = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] in_data,
  output pipe_occ_e        state,
  output logic [WIDTH-1:0] main
);

  pipe_occ_e        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end else if (push && SKID) begin
            // Only reachable with a skid entry; without one in_ready blocks this.
            state_d = FULL;
            skid_d  = in_data;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = BUSY;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID) begin : g_skid
    always_ff @(posedge clk) begin
      if (reset) skid_q <= BUBBLE;
      else       skid_q <= skid_d;
    end
  end else begin : g_no_skid
    assign skid_q = BUBBLE;
    logic unused_skid;
    assign unused_skid = ^skid_d;
  end

  assign state = state_q;
  assign main  = main_q;

endmodule

// File: rtl/cpu_pipe_stage.sv
// cpu_pipe_stage: generic valid/ready pipeline stage register for any CPU
// stage boundary, with flush-to-bubble and a saturating stall counter.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_data is the payload
//   flush                kill held and incoming payloads this cycle
//   out_valid/out_ready  downstream handshake; out_data = BUBBLE when empty
//   stall_cnt            saturating count of out_valid & !out_ready cycles
module cpu_pipe_stage
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter bit               SKID   = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_occ_e        state;
  logic             push, pop;
  logic [CNT_W-1:0] stall_q;

  if (SKID) begin : g_rdy_skid
    // Registered backpressure: no path from out_ready.
    assign in_ready = !flush && (state != FULL);
  end else begin : g_rdy_comb
    assign in_ready = !flush && ((state == EMPTY) || out_ready);
  end

  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  cpu_pipe_skid #(
    .WIDTH  (WIDTH),
    .SKID   (SKID),
    .BUBBLE (BUBBLE)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .in_data (in_data),
    .state   (state),
    .main    (out_data)
  );

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_cpu_pipe_stage.sv
// Bench for cpu_pipe_stage: drives identical stimulus into a SKID=1 and a
// SKID=0 instance and compares each against a queue-based reference model.
module tb_cpu_pipe_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, flush, out_ready;
  logic [7:0] in_data;

  logic       rdy1, ov1, rdy0, ov0;
  logic [7:0] od1, od0;
  logic [3:0] sc1, sc0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO contents and stall counts per instance.
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  int         cnt1, cnt0;

  always #5 clk = ~clk;

  cpu_pipe_stage #(.WIDTH(8), .SKID(1'b1), .BUBBLE(8'hFF), .CNT_W(4)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (rdy1),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (ov1),
    .out_ready (out_ready),
    .out_data  (od1),
    .stall_cnt (sc1)
  );

  cpu_pipe_stage #(.WIDTH(8), .SKID(1'b0), .BUBBLE(8'hFF), .CNT_W(4)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (rdy0),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (ov0),
    .out_ready (out_ready),
    .out_data  (od0),
    .stall_cnt (sc0)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string phase);
    check({phase, " s1 out_valid"}, 16'(ov1), 16'(q1.size() != 0));
    check({phase, " s1 out_data"}, 16'(od1), 16'((q1.size() != 0) ? q1[0] : 8'hFF));
    check({phase, " s1 stall_cnt"}, 16'(sc1), 16'(cnt1));
    check({phase, " s0 out_valid"}, 16'(ov0), 16'(q0.size() != 0));
    check({phase, " s0 out_data"}, 16'(od0), 16'((q0.size() != 0) ? q0[0] : 8'hFF));
    check({phase, " s0 stall_cnt"}, 16'(sc0), 16'(cnt0));
  endtask

  // One clock: apply inputs, check in_ready, advance model, check outputs.
  task automatic cycle(input string phase, input logic iv, input logic ordy,
                       input logic fl, input logic [7:0] d);
    logic er1, er0, push1, push0, pop1, pop0, st1, st0;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = d;
    #1;
    er1 = !fl && (q1.size() < 2);
    er0 = !fl && ((q0.size() == 0) || ordy);
    check({phase, " s1 in_ready"}, 16'(rdy1), 16'(er1));
    check({phase, " s0 in_ready"}, 16'(rdy0), 16'(er0));
    push1 = iv && er1;
    push0 = iv && er0;
    pop1  = (q1.size() != 0) && ordy;
    pop0  = (q0.size() != 0) && ordy;
    st1   = (q1.size() != 0) && !ordy;
    st0   = (q0.size() != 0) && !ordy;
    @(posedge clk);
    #1;
    if (pop1) void'(q1.pop_front());
    if (pop0) void'(q0.pop_front());
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (push1) q1.push_back(d);
      if (push0) q0.push_back(d);
    end
    if (st1 && cnt1 < 15) cnt1++;
    if (st0 && cnt0 < 15) cnt0++;
    check_outputs(phase);
  endtask

  // Reset with in_valid/flush asserted to show reset wins.
  task automatic do_reset(input string phase);
    reset     = 1'b1;
    in_valid  = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b0;
    in_data   = 8'h5A;
    @(posedge clk);
    #1;
    q1.delete();
    q0.delete();
    cnt1 = 0;
    cnt0 = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_outputs(phase);
    #1;
    check({phase, " s1 in_ready after reset"}, 16'(rdy1), 16'd1);
    check({phase, " s0 in_ready after reset"}, 16'(rdy0), 16'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    cnt1      = 0;
    cnt0      = 0;
    @(posedge clk);
    do_reset("reset");

    // Streaming 0x01..0x10 at full rate.
    for (int i = 1; i <= 16; i++) cycle("stream", 1'b1, 1'b1, 1'b0, 8'(i));
    cycle("stream drain", 1'b0, 1'b1, 1'b0, 8'h00);
    check("stream s1 no stalls", 16'(sc1), 16'd0);
    check("stream s0 no stalls", 16'(sc0), 16'd0);

    // Backpressure: 0x03 held upstream until accepted.
    cycle("bp", 1'b1, 1'b0, 1'b0, 8'h01);
    cycle("bp", 1'b1, 1'b0, 1'b0, 8'h02);
    cycle("bp", 1'b1, 1'b0, 1'b0, 8'h03);
    cycle("bp", 1'b1, 1'b0, 1'b0, 8'h03);
    cycle("bp", 1'b1, 1'b1, 1'b0, 8'h03);
    cycle("bp", 1'b1, 1'b1, 1'b0, 8'h03);
    cycle("bp", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("bp", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("bp", 1'b0, 1'b1, 1'b0, 8'h00);

    // Flush while full with 0x07 offered.
    do_reset("pre-flush reset");
    cycle("fill", 1'b1, 1'b0, 1'b0, 8'h0A);
    cycle("fill", 1'b1, 1'b0, 1'b0, 8'h0B);
    cycle("flush", 1'b1, 1'b0, 1'b1, 8'h07);
    check("flush s1 out_data", 16'(od1), 16'h00FF);
    cycle("post-flush", 1'b0, 1'b1, 1'b0, 8'h00);

    // Stall counter saturation, survives flush, cleared by reset.
    cycle("sat fill", 1'b1, 1'b0, 1'b0, 8'h33);
    for (int i = 0; i < 20; i++) cycle("sat", 1'b0, 1'b0, 1'b0, 8'h00);
    check("sat s1 stall_cnt", 16'(sc1), 16'd15);
    check("sat s0 stall_cnt", 16'(sc0), 16'd15);
    cycle("sat flush", 1'b0, 1'b0, 1'b1, 8'h00);
    check("sat flush s1 stall_cnt", 16'(sc1), 16'd15);
    do_reset("sat reset");

    // Reset mid-stream while full.
    cycle("mid fill", 1'b1, 1'b0, 1'b0, 8'h44);
    cycle("mid fill", 1'b1, 1'b0, 1'b0, 8'h55);
    do_reset("mid reset");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 23) == 0), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
